// File: rtl/store_size_rmw.sv
// Word/half/byte store engine: word writes directly, half/byte do read-modify-write of the low lane.
// Latency: word 2, no-store 1, half/byte 3+MEM_LATENCY cycles to done; start is ignored while busy.
module store_size_rmw #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ss_control,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_ctrl;
    logic [31:0] r_merge;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr_hold;
    logic [31:0] r_wdata_hold;
    logic [31:0] w_merged;
    logic        w_rd;
    logic        w_wr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (ss_control)
                        2'b01:   w_next = S_WRITE;
                        2'b10,
                        2'b11:   w_next = S_READ;
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_READ:  w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sub-word lanes are always the low bits of the word, mirroring the load side.
    always_comb begin
        w_merged = r_data;
        case (r_ctrl)
            2'b10:   w_merged = {r_merge[31:16], r_data[15:0]};
            2'b11:   w_merged = {r_merge[31:8], r_data[7:0]};
            default: w_merged = r_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_ctrl       <= '0;
            r_merge      <= '0;
            r_cnt        <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_addr <= addr;
                r_data <= reg_data;
                r_ctrl <= ss_control;
            end
            if (r_state == S_READ) begin
                r_cnt <= LAT;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) r_merge <= mem_rdata;
            end
            if (w_rd || w_wr) r_addr_hold <= r_addr;
            if (w_wr) r_wdata_hold <= w_merged;
        end
    end

    assign w_rd = (r_state == S_READ);
    assign w_wr = (r_state == S_WRITE);

    // Outside READ/WRITE the bus shows the last driven values rather than the next request.
    assign mem_rd    = w_rd;
    assign mem_wr    = w_wr;
    assign mem_addr  = (w_rd || w_wr) ? r_addr : r_addr_hold;
    assign mem_wdata = w_wr ? w_merged : r_wdata_hold;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_store_size_rmw.sv
// Drives two store_size_rmw instances (MEM_LATENCY 2 and 1) against a transaction-schedule model.
module tb_store_size_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  ss_control;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic [31:0] rdat0;
    logic [31:0] rdat1;

    wire [1:0]        rd_o;
    wire [1:0]        wr_o;
    wire [1:0]        busy_o;
    wire [1:0]        done_o;
    wire [1:0][31:0]  maddr_o;
    wire [1:0][31:0]  wdata_o;

    logic [31:0] mem [16];

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int          acc_at [2];
    int          rd_at  [2];
    int          wr_at  [2];
    int          done_at[2];
    logic [31:0] ex_addr [2];
    logic [31:0] ex_wdata[2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];

    store_size_rmw #(.MEM_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .start(start), .ss_control(ss_control),
        .addr(addr), .reg_data(reg_data), .mem_rdata(rdat0),
        .mem_addr(maddr_o[0]), .mem_rd(rd_o[0]), .mem_wr(wr_o[0]),
        .mem_wdata(wdata_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    store_size_rmw #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .start(start), .ss_control(ss_control),
        .addr(addr), .reg_data(reg_data), .mem_rdata(rdat1),
        .mem_addr(maddr_o[1]), .mem_rd(rd_o[1]), .mem_wr(wr_o[1]),
        .mem_wdata(wdata_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    always #5 clk = ~clk;

    // Memory responders: read data is correct only on the one edge L cycles after the read cycle.
    int          pend0 = 0;
    int          pend1 = 0;
    logic [31:0] raddr0;
    logic [31:0] raddr1;

    always @(posedge clk) begin
        #1;
        if (pend0 > 0) begin
            pend0--;
            rdat0 = (pend0 == 0) ? mem[raddr0[5:2]] : $urandom;
        end else begin
            rdat0 = $urandom;
        end
        if (reset) pend0 = 0;
        if (rd_o[0]) begin
            pend0  = 2;
            raddr0 = maddr_o[0];
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend1 > 0) begin
            pend1--;
            rdat1 = (pend1 == 0) ? mem[raddr1[5:2]] : $urandom;
        end else begin
            rdat1 = $urandom;
        end
        if (reset) pend1 = 0;
        if (rd_o[1]) begin
            pend1  = 1;
            raddr1 = maddr_o[1];
        end
    end

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_at[k]   = -100;
            rd_at[k]    = -100;
            wr_at[k]    = -100;
            done_at[k]  = -100;
            ex_addr[k]  = '0;
            ex_wdata[k] = '0;
        end
    endtask

    // Indices are observation points: cyc = number of the edge just taken.
    task automatic model_edge();
        logic [31:0] mask;
        logic [31:0] old;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (start && cyc >= done_at[k] + 2) begin
                acc_at[k] = cyc;
                p_addr[k] = addr;
                case (ss_control)
                    2'b01: begin
                        rd_at[k]   = -100;
                        wr_at[k]   = cyc;
                        done_at[k] = cyc + 1;
                        p_wdata[k] = reg_data;
                    end
                    2'b10, 2'b11: begin
                        mask       = (ss_control == 2'b10) ? 32'h0000_FFFF : 32'h0000_00FF;
                        old        = mem[addr[5:2]];
                        rd_at[k]   = cyc;
                        wr_at[k]   = cyc + 1 + lat(k);
                        done_at[k] = cyc + 2 + lat(k);
                        p_wdata[k] = (old & ~mask) | (reg_data & mask);
                    end
                    default: begin
                        rd_at[k]   = -100;
                        wr_at[k]   = -100;
                        done_at[k] = cyc;
                    end
                endcase
            end
            if (cyc == rd_at[k] || cyc == wr_at[k]) ex_addr[k] = p_addr[k];
            if (cyc == wr_at[k]) ex_wdata[k] = p_wdata[k];
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s inst%0d cyc=%0d got=%h exp=%h", tag, k, cyc, got, exp);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("mem_rd",    k, 32'(rd_o[k]),   32'(cyc == rd_at[k]));
            chk("mem_wr",    k, 32'(wr_o[k]),   32'(cyc == wr_at[k]));
            chk("done",      k, 32'(done_o[k]), 32'(cyc == done_at[k]));
            chk("busy",      k, 32'(busy_o[k]), 32'(cyc >= acc_at[k] && cyc <= done_at[k]));
            chk("mem_addr",  k, maddr_o[k],     ex_addr[k]);
            chk("mem_wdata", k, wdata_o[k],     ex_wdata[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic scramble();
        ss_control = 2'($urandom);
        addr       = $urandom;
        reg_data   = $urandom;
    endtask

    task automatic pulse(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        ss_control = c;
        addr       = a;
        reg_data   = d;
        start      = 1'b1;
        step();
        start = 1'b0;
        scramble();
    endtask

    task automatic idle(input int n, input bit rand_start);
        for (int i = 0; i < n; i++) begin
            scramble();
            start = rand_start ? ($urandom_range(0, 5) == 0) : 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h1122_3344;
        rdat0  = '0;
        rdat1  = '0;
        reset  = 1'b1;
        start  = 1'b0;
        scramble();
        model_reset();

        // Reset state, with start held to show it is ignored in reset.
        #1;
        check_all();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        reset = 1'b0;
        idle(2, 0);

        // Word, halfword and byte stores to the directed addresses.
        pulse(2'b01, 32'h0000_0040, 32'hDEAD_BEEF);
        idle(4, 0);
        pulse(2'b10, 32'h0000_0080, 32'hAAAA_BBBB);
        idle(7, 0);
        pulse(2'b11, 32'h0000_0080, 32'h0000_00FF);
        idle(7, 0);

        // Second start during WAIT and during DONE of the slower instance.
        pulse(2'b11, 32'h0000_0080, 32'h1234_5678);
        step();
        ss_control = 2'b01;
        reg_data   = 32'h5555_5555;
        addr       = 32'h0000_0044;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        ss_control = 2'b01;
        reg_data   = 32'h5555_5555;
        start      = 1'b1;
        step();
        start = 1'b0;
        idle(6, 0);

        // Asynchronous reset in the first WAIT cycle of a byte store.
        pulse(2'b11, 32'h0000_0080, 32'h0000_00FF);
        step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        step();
        reset = 1'b0;
        idle(2, 0);
        pulse(2'b01, 32'h0000_0048, 32'hCAFE_F00D);
        idle(4, 0);

        // No-store request.
        pulse(2'b00, 32'h0000_004C, 32'h0BAD_0BAD);
        idle(3, 0);

        // Random requests with stray start pulses while busy.
        for (int i = 0; i < 60; i++) begin
            pulse(2'($urandom), $urandom, $urandom);
            idle($urandom_range(0, 8), 1);
        end
        idle(8, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/store_size_rmw.md
Name: store_size_rmw

Overview:
- Store-side counterpart of the load-size extractor. Performs `sw`/`sh`/`sb` by writing a full 32-bit word to data memory.
- Word stores write directly. Halfword and byte stores do a read-modify-write: read the word at `addr`, replace bits [15:0] or [7:0] with the low bits of `reg_data`, write the merged word back.
- Byte/half lanes are always the low lanes of the addressed word, matching the load-side extraction.
- Sits between the control FSM/register file and the data memory port.

Parameters:
- MEM_LATENCY, 2, cycles from the `mem_rd` cycle to the edge where `mem_rdata` is valid; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled only in IDLE
- `ss_control`  in  2  01=word, 10=halfword, 11=byte, 00=no store
- `addr`  in  32  byte address of the store
- `reg_data`  in  32  source register value
- `mem_rdata`  in  32  memory read data
- `mem_addr`  out  32  memory address (latched `addr`, unmodified)
- `mem_rd`  out  1  memory read strobe, one cycle
- `mem_wr`  out  1  memory write strobe, one cycle
- `mem_wdata`  out  32  write data; valid when `mem_wr`=1
- `busy`  out  1  1 whenever state != IDLE
- `done`  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate):
  - State to IDLE.
  - `mem_rd`, `mem_wr`, `done`, `busy` = 0; `mem_addr`, `mem_wdata` = 0.
  - Internal latches (addr, data, control, merge register) and the wait counter = 0.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE, `start`=1 at edge S:
  - Latch `addr`, `reg_data`, `ss_control`.
  - Next state: ctrl 01 -> WRITE; ctrl 10/11 -> READ; ctrl 00 -> DONE (no memory access).
- IDLE, `start`=0: stay in IDLE.
- READ:
  - One cycle with `mem_rd`=1 and `mem_addr`=latched addr.
  - Load wait counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter reads 1, capture `mem_rdata` into the merge register and go to WRITE.
  - WAIT therefore lasts exactly MEM_LATENCY cycles.
- WRITE:
  - One cycle with `mem_wr`=1 and `mem_addr`=latched addr; then go to DONE.
  - `mem_wdata` by latched ctrl:
    - word: latched `reg_data`
    - half: {merge[31:16], `reg_data`[15:0]}
    - byte: {merge[31:8], `reg_data`[7:0]}
- DONE: `done`=1 for one cycle; then IDLE.
- Latency, with `start` at edge S:
  - word: `mem_wr` in cycle S+1, `done` at S+2.
  - half/byte: `mem_rd` at S+1, WAIT S+2..S+1+L, `mem_wr` at S+2+L, `done` at S+3+L (L = MEM_LATENCY).
  - no-store: `done` at S+1.
- Inputs are ignored while busy:
  - `start` outside IDLE (including the DONE cycle) is dropped; a new request needs `start` in IDLE.
  - `ss_control`, `addr` and `reg_data` changing after acceptance have no effect.
- `mem_rd` and `mem_wr` are never high in the same cycle. Each is high for at most one cycle per request.
- `mem_wdata` and `mem_addr` hold their last values outside READ/WRITE; they are 0 after reset.
- Reset asserted mid-operation aborts the request:
  - No later `mem_rd`, `mem_wr` or `done` for that request.
  - Reset during WRITE deasserts `mem_wr` immediately (combinational clear via state).
- All outputs are driven from registered state and latches, so no combinational path runs from inputs to `mem_*` or `done`.

Test Plan:
- Word store: MEM_LATENCY=2, `addr`=0x40, `reg_data`=0xDEADBEEF, ctrl 01, `start` at S -> `mem_wr`=1 only at S+1 with `mem_addr`=0x40, `mem_wdata`=0xDEADBEEF; `mem_rd` never high; `done` at S+2; `busy` high S+1..S+2.
- Halfword store: memory word 0x11223344 at 0x80, `reg_data`=0xAAAABBBB, ctrl 10 -> `mem_rd` at S+1; `mem_wr` at S+4 with `mem_wdata`=0x1122BBBB; `done` at S+5.
- Byte store: same memory word, `reg_data`=0x000000FF, ctrl 11; repeat with MEM_LATENCY=1 -> `mem_wdata`=0x112233FF; `mem_wr` at S+4 (L=2) and S+3 (L=1).
- Busy rejection: second `start` (ctrl 01, data 0x55555555) pulsed during WAIT and during the DONE cycle -> exactly one `mem_wr`, carrying the first request's data; no second `done`.
- Reset mid-op: assert `reset` in the first WAIT cycle of a byte store -> all outputs 0 immediately; no `mem_wr` or `done` ever for that request; a fresh word store after reset completes normally.
- No-store: ctrl 00 with `start` -> `done` at S+1; `mem_rd` and `mem_wr` stay 0.
